// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
package uart_pkg;

    // Receiver/transmitter FSM encoding, also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS        = 8;
    localparam int CLK_HZ           = 12_000_000;
    localparam int BAUD             = 9600;
    localparam int CLKS_PER_BIT_DEF = 1250;

    // Mid-bit offset in clocks, rounded down.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer with a selectable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to settle an asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, one-cycle data/error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state,
    output logic [3:0] bit_count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = half_bit(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

    uart_state_t          st;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Receive FSM: start confirmation at mid-bit, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            count      <= '0;
            bit_count  <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                IDLE: begin
                    count     <= '0;
                    bit_count <= '0;
                    if (!rx_s) begin
                        st <= START;
                    end
                end
                START: begin
                    if (count == HALF_M1) begin
                        count <= '0;
                        if (!rx_s) begin
                            st <= DATA;
                        end else begin
                            st <= IDLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DATA: begin
                    if (count == BIT_M1) begin
                        count     <= '0;
                        shreg     <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == LAST_BIT) begin
                            st <= STOP;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STOP: begin
                    // Returning at mid-stop-bit leaves half a bit to catch the next start edge.
                    if (count == BIT_M1) begin
                        count <= '0;
                        st    <= IDLE;
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    st    <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign state = st;
    assign busy  = (st != IDLE);

    // A frame ends either good or bad, never both.
    assert property (@(posedge clk) disable iff (rst) !(data_valid && frame_err));

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default-rate instance and a minimum-rate instance.
module tb_uart_rx;

    localparam int CPB_A = 1250;
    localparam int CPB_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rx_a, dv_a, fe_a, busy_a;
    logic [7:0] dout_a;
    logic [1:0] st_a;
    logic [3:0] bc_a;
    logic       rst_b, rx_b, dv_b, fe_b, busy_b;
    logic [7:0] dout_b;
    logic [1:0] st_b;
    logic [3:0] bc_b;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst(rst_a), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
        .frame_err(fe_a), .busy(busy_a), .state(st_a), .bit_count(bc_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst(rst_b), .rx(rx_b), .data_out(dout_b), .data_valid(dv_b),
        .frame_err(fe_b), .busy(busy_b), .state(st_b), .bit_count(bc_b)
    );

    typedef struct {
        longint     cyc;
        logic [7:0] data;
        bit         err;
    } ev_t;

    ev_t    q_a[$];
    ev_t    q_b[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    bit     chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drive one 10-bit frame; call aligned #1 after a rising edge, returns aligned.
    task automatic send_frame(input bit inst, input logic [7:0] b, input bit stop_bit,
                              input bit track, output longint e0);
        int         cpb;
        logic [9:0] bits;
        ev_t        ev;
        cpb  = inst ? CPB_B : CPB_A;
        bits = {stop_bit, b, 1'b0};
        e0   = cyc + 1;
        if (track) begin
            ev.cyc  = e0 + 2 + cpb / 2 + 9 * cpb;
            ev.data = b;
            ev.err  = !stop_bit;
            if (inst) q_b.push_back(ev);
            else      q_a.push_back(ev);
        end
        for (int k = 0; k < 10; k++) begin
            if (inst) rx_b = bits[k];
            else      rx_a = bits[k];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input longint target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    // Model state and observation records.
    logic       rst_q_a = 1'b1, rst_q_b = 1'b1;
    logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
    longint     pulse_a[$];
    longint     last_dv_b = 0;
    int         dv_cnt_b = 0, fe_cnt_b = 0, dv_cnt_a = 0;

    always @(posedge clk) begin
        rst_q_a <= rst_a;
        rst_q_b <= rst_b;
    end

    // Per-cycle comparison of both instances against the expected-event queues.
    always @(negedge clk) begin
        bit  v, e;
        ev_t ev;
        if (chk_on) begin
            v = 1'b0; e = 1'b0;
            if (rst_q_a) exp_a = 8'h00;
            while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
                ev = q_a.pop_front();
                check("a.missed_event", 0, 1);
            end
            if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
                ev = q_a.pop_front();
                e  = ev.err;
                v  = !ev.err;
                if (v) exp_a = ev.data;
            end
            check("a.data_valid", dv_a, v);
            check("a.frame_err", fe_a, e);
            check("a.data_out", dout_a, exp_a);
            check("a.busy", busy_a, st_a != 2'd0);
            if (dv_a) begin
                pulse_a.push_back(cyc);
                dv_cnt_a++;
            end

            v = 1'b0; e = 1'b0;
            if (rst_q_b) exp_b = 8'h00;
            while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
                ev = q_b.pop_front();
                check("b.missed_event", 0, 1);
            end
            if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
                ev = q_b.pop_front();
                e  = ev.err;
                v  = !ev.err;
                if (v) exp_b = ev.data;
            end
            check("b.data_valid", dv_b, v);
            check("b.frame_err", fe_b, e);
            check("b.data_out", dout_b, exp_b);
            check("b.busy", busy_b, st_b != 2'd0);
            if (dv_b) begin
                dv_cnt_b++;
                last_dv_b = cyc;
            end
            if (fe_b) fe_cnt_b++;
        end
    end

    // Default-rate scenarios: latency, back-to-back frames, glitch rejection.
    task automatic seq_a();
        longint e0, e1, g0;
        int     n0;
        idle(100);
        send_frame(1'b0, 8'h53, 1'b1, 1'b1, e0);
        idle(20);
        check("a.first_count", pulse_a.size(), 1);
        if (pulse_a.size() >= 1) check("a.first_latency", pulse_a[0] - e0, 11877);
        check("a.first_byte", dout_a, 8'h53);

        pulse_a.delete();
        send_frame(1'b0, 8'h6E, 1'b1, 1'b1, e1);
        send_frame(1'b0, 8'h61, 1'b1, 1'b1, e0);
        send_frame(1'b0, 8'h70, 1'b1, 1'b1, e0);
        idle(20);
        check("a.b2b_count", pulse_a.size(), 3);
        if (pulse_a.size() == 3) begin
            check("a.b2b_gap1", pulse_a[1] - pulse_a[0], 12500);
            check("a.b2b_gap2", pulse_a[2] - pulse_a[1], 12500);
            check("a.b2b_latency", pulse_a[0] - e1, 11877);
        end
        check("a.b2b_last_byte", dout_a, 8'h70);

        n0 = dv_cnt_a;
        g0 = cyc + 1;
        rx_a = 1'b0;
        idle(300);
        rx_a = 1'b1;
        wait_neg(g0 + 626);
        check("a.glitch_still_start", st_a, 2'd1);
        @(negedge clk);
        check("a.glitch_idle_at_627", st_a, 2'd0);
        idle(200);
        check("a.glitch_no_strobe", dv_cnt_a, n0);
        check("a.glitch_byte_kept", dout_a, 8'h70);
    endtask

    // Minimum-rate scenarios: framing error, mid-frame reset, loopback stream.
    task automatic seq_b();
        longint e0;
        int     dv0, fe0;
        bit     found;
        logic [7:0] b;
        idle(10);
        send_frame(1'b1, 8'h5A, 1'b1, 1'b1, e0);
        idle(5);
        check("b.first_latency", last_dv_b - e0, 40);
        check("b.first_byte", dout_b, 8'h5A);

        dv0 = dv_cnt_b;
        send_frame(1'b1, 8'hA5, 1'b0, 1'b1, e0);
        rx_b = 1'b1;
        idle(20);
        check("b.ferr_count", fe_cnt_b, 1);
        check("b.ferr_no_valid", dv_cnt_b, dv0);
        check("b.ferr_byte_kept", dout_b, 8'h5A);

        dv0 = dv_cnt_b;
        fork
            send_frame(1'b1, 8'hFF, 1'b1, 1'b0, e0);
            begin
                found = 1'b0;
                for (int i = 0; i < 200 && !found; i++) begin
                    @(negedge clk);
                    if (bc_b == 4'd4) found = 1'b1;
                end
                check("b.abort_bitcount_reached", found, 1);
                rst_b = 1'b1;
                @(posedge clk);
                #1;
                rst_b = 1'b0;
                check("b.rst_data_out", dout_b, 8'h00);
                check("b.rst_valid", dv_b, 0);
                check("b.rst_ferr", fe_b, 0);
                check("b.rst_busy", busy_b, 0);
                check("b.rst_state", st_b, 2'd0);
                check("b.rst_bit_count", bc_b, 4'd0);
            end
        join
        idle(10);
        check("b.abort_no_strobe", dv_cnt_b, dv0);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1, e0);
        idle(5);
        check("b.after_abort_byte", dout_b, 8'h3C);

        dv0 = dv_cnt_b;
        fe0 = fe_cnt_b;
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom % 256);
            send_frame(1'b1, b, 1'b1, 1'b1, e0);
        end
        idle(10);
        check("b.loop_valid_count", dv_cnt_b - dv0, 100);
        check("b.loop_ferr_count", fe_cnt_b - fe0, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rx_a  = 1'b1; rx_b  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        check("a.reset_data_out", dout_a, 8'h00);
        check("a.reset_valid", dv_a, 0);
        check("a.reset_ferr", fe_a, 0);
        check("a.reset_busy", busy_a, 0);
        check("a.reset_state", st_a, 2'd0);
        check("a.reset_bit_count", bc_a, 4'd0);
        check("b.reset_data_out", dout_b, 8'h00);
        check("b.reset_state", st_b, 2'd0);
        chk_on = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        idle(20);
        check("a.pending_events", q_a.size(), 0);
        check("b.pending_events", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
